operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage directly downstream of the 8-entry register file.
- Drives the register file's two asynchronous read addresses and captures the read data into an output pipeline register for the execute stage.
- Bypasses same-cycle writeback data and tracks outstanding destination writes in a scoreboard.
- Stalls upstream on RAW/WAW hazards using a valid/ready handshake.

Parameters:
- DATA_W, 24, operand and writeback data width; equals the register-file data width.
- OP_W, 6, width of the opaque opcode/control field carried through.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  OP_W  opcode/control bits.
- in_rs1, in_rs2  in  3  source register indices.
- in_use1, in_use2  in  1  the instruction reads rs1 / rs2.
- in_rd  in  3  destination register index.
- in_rd_we  in  1  the instruction writes rd.
- rf_a1, rf_a2  out  3  register-file read addresses.
- rf_rd1, rf_rd2  in  DATA_W  register-file read data (asynchronous).
- wb_we  in  1  writeback enable; same signal as the register-file write enable.
- wb_addr  in  3  writeback register index.
- wb_data  in  DATA_W  writeback data.
- flush  in  1  discard the held output instruction.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  execute stage consumes it.
- out_op  out  OP_W  registered opcode.
- out_opa, out_opb  out  DATA_W  registered operands.
- out_rd  out  3  registered destination index.
- out_rd_we  out  1  registered destination write enable.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0; out_op, out_opa, out_opb, out_rd, out_rd_we=0; scoreboard pend[7:0]=0; stall_cnt=0. All state is held while rst=0.
- Read addressing: rf_a1=in_rs1 and rf_a2=in_rs2, combinational and always driven.
- Operand select for each source s:
  - s==0 -> 0.
  - else wb_we && wb_addr==s -> wb_data (bypass; the register-file write lands only at the edge).
  - else rf_rdN.
- Hazard terms:
  - raw = (in_use1 && rs1!=0 && pend[rs1] && !(wb_we && wb_addr==rs1)) || the same term for rs2.
  - waw = in_rd_we && rd!=0 && pend[rd] && !(wb_we && wb_addr==rd).
  - hazard = raw || waw.
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready) && !flush.
  - issue = in_valid && in_ready.
  - in_ready must not depend on in_valid.
- Output register FSM, two states:
  - EMPTY (out_valid=0): issue -> HOLD (load fields).
  - HOLD (out_valid=1):
    - out_ready && issue -> HOLD with new fields (back-to-back, 1 instruction/cycle).
    - out_ready && !issue -> EMPTY.
    - !out_ready -> HOLD with fields stable.
  - flush (any state) -> EMPTY; no issue occurs that cycle.
- Latency: 1 cycle from accept to out_valid.
- Scoreboard:
  - Set pend[in_rd] on issue when in_rd_we && in_rd!=0.
  - Clear pend[wb_addr] when wb_we && wb_addr!=0.
  - Same-index set and clear in one cycle: set wins.
  - pend[0] is never set.
- Flush while out_valid && out_rd_we && out_rd!=0: clear pend[out_rd], unless wb_we targets the same index, which is harmless; flush takes priority over any concurrent set.
- stall_cnt increments each cycle with in_valid && hazard; saturates at all-ones and never wraps.
- A writeback to x0 is ignored for both bypass and scoreboard.

Test Plan:
- Reset, then issue r1=r0+r0 with out_ready=1 -> out_valid=1 the next cycle, out_opa=0, out_opb=0, pend[1]=1; assert rst=0 mid-stream -> out_valid=0 and pend=0 immediately, without waiting for a clock edge.
- Issue a write to r3, then a reader of r3 with no writeback -> in_ready=0 and stall_cnt counts 1, 2, 3; pulse wb_we=1, wb_addr=3, wb_data=24'h00ABCD -> accepted that same cycle with out_opa=24'h00ABCD (bypass), pend[3]=0.
- rf_rd1=24'h000011 with a simultaneous writeback to the same rs1 carrying 24'h000022 -> out_opa=24'h000022.
- out_ready=0 for 4 cycles while HOLD -> output fields stable, in_ready=0; raise out_ready with a waiting instruction -> back-to-back transfer, out_valid stays 1.
- WAW: pending r5, new instruction writes r5 -> stall until wb to r5; issue plus wb to r5 in the same cycle -> pend[5]=1 (set wins).
- Flush while holding a writer of r6 -> out_valid=0 and pend[6]=0 next cycle; force 2^CNT_W+3 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch with writeback bypass, scoreboard and hazard stall
module operand_fetch_stage #(
  parameter int DATA_W = 24,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic [2:0]        in_rd,
  input  logic              in_rd_we,
  output logic [2:0]        rf_a1,
  output logic [2:0]        rf_a2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              wb_we,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_opa,
  output logic [DATA_W-1:0] out_opb,
  output logic [2:0]        out_rd,
  output logic              out_rd_we,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t              state_q, state_d;
  logic [7:0]          pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   opa_q, opb_q, opa_d, opb_d;
  logic [2:0]          rd_q;
  logic                rd_we_q;
  logic                wb_live, hit1, hit2, hitd;
  logic                raw, waw, hazard, issue, load;

  assign rf_a1 = in_rs1;
  assign rf_a2 = in_rs2;

  // Writeback to x0 is ignored everywhere, so fold that into a single qualifier.
  assign wb_live = wb_we && (wb_addr != 3'd0);
  assign hit1    = wb_live && (wb_addr == in_rs1);
  assign hit2    = wb_live && (wb_addr == in_rs2);
  assign hitd    = wb_live && (wb_addr == in_rd);

  assign opa_d = (in_rs1 == 3'd0) ? '0 : (hit1 ? wb_data : rf_rd1);
  assign opb_d = (in_rs2 == 3'd0) ? '0 : (hit2 ? wb_data : rf_rd2);

  assign raw = (in_use1 && (in_rs1 != 3'd0) && pend_q[in_rs1] && !hit1) ||
               (in_use2 && (in_rs2 != 3'd0) && pend_q[in_rs2] && !hit2);
  assign waw = in_rd_we && (in_rd != 3'd0) && pend_q[in_rd] && !hitd;
  assign hazard = raw || waw;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !hazard && (!out_valid || out_ready) && !flush;
  assign issue     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (issue) begin
          state_d = HOLD;
          load    = 1'b1;
        end
        HOLD: if (out_ready) begin
          if (issue) load = 1'b1;
          else       state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Order matters: clear, then set (set wins), then flush release (flush wins).
  always_comb begin
    pend_d = pend_q;
    if (wb_live) pend_d[wb_addr] = 1'b0;
    if (issue && in_rd_we && (in_rd != 3'd0)) pend_d[in_rd] = 1'b1;
    if (flush && out_valid && rd_we_q && (rd_q != 3'd0)) pend_d[rd_q] = 1'b0;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && hazard && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      pend_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q    <= in_op;
        opa_q   <= opa_d;
        opb_q   <= opb_d;
        rd_q    <= in_rd;
        rd_we_q <= in_rd_we;
      end
    end
  end

  assign out_op    = op_q;
  assign out_opa   = opa_q;
  assign out_opb   = opb_q;
  assign out_rd    = rd_q;
  assign out_rd_we = rd_we_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_op;
  logic [2:0]  in_rs1, in_rs2, in_rd;
  logic        in_use1, in_use2, in_rd_we;
  logic [2:0]  rf_a1, rf_a2;
  logic [23:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [23:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [5:0]  out_op;
  logic [23:0] out_opa, out_opb;
  logic [2:0]  out_rd;
  logic        out_rd_we;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_opa(out_opa), .out_opb(out_opb), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_use1 = 0; in_use2 = 0;
    in_rd = 0; in_rd_we = 0; rf_rd1 = 0; rf_rd2 = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    tick();
    tick();
    rst = 1;
  endtask

  task automatic present(input logic [5:0] op, input logic [2:0] rs1, input logic u1,
                         input logic [2:0] rs2, input logic u2,
                         input logic [2:0] rd, input logic we);
    in_valid = 1; in_op = op; in_rs1 = rs1; in_use1 = u1;
    in_rs2 = rs2; in_use2 = u2; in_rd = rd; in_rd_we = we;
  endtask

  initial begin
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_opa", out_opa, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_pend", dut.pend_q, 0);

    // r1 = r0 + r0: x0 reads as zero regardless of rf data
    rf_rd1 = 24'h123456; rf_rd2 = 24'h654321;
    present(6'h15, 3'd0, 1, 3'd0, 1, 3'd1, 1);
    #1 check("t1_in_ready", in_ready, 1);
    check("t1_rf_a1", rf_a1, 0);
    tick();
    in_valid = 0;
    check("t1_out_valid", out_valid, 1);
    check("t1_out_opa", out_opa, 0);
    check("t1_out_opb", out_opb, 0);
    check("t1_out_op", out_op, 6'h15);
    check("t1_out_rd", out_rd, 1);
    check("t1_pend1", dut.pend_q[1], 1);
    #2 rst = 0;
    #1 check("async_rst_out_valid", out_valid, 0);
    check("async_rst_pend", dut.pend_q, 0);
    tick();
    rst = 1;

    // RAW stall then bypass release
    do_reset();
    present(6'h01, 3'd0, 0, 3'd0, 0, 3'd3, 1);
    tick();
    present(6'h02, 3'd3, 1, 3'd0, 0, 3'd4, 1);
    #1 check("raw_in_ready", in_ready, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("raw_stall_cnt%0d", i), stall_cnt, i);
    end
    wb_we = 1; wb_addr = 3'd3; wb_data = 24'h00ABCD;
    #1 check("raw_wb_in_ready", in_ready, 1);
    tick();
    wb_we = 0; in_valid = 0;
    check("raw_out_opa", out_opa, 24'h00ABCD);
    check("raw_pend3", dut.pend_q[3], 0);
    check("raw_pend4", dut.pend_q[4], 1);
    check("raw_stall_hold", stall_cnt, 3);

    // bypass beats register-file data; x0 writeback ignored
    do_reset();
    rf_rd1 = 24'h000011; rf_rd2 = 24'h000033;
    wb_we = 1; wb_addr = 3'd2; wb_data = 24'h000022;
    present(6'h03, 3'd2, 1, 3'd7, 1, 3'd0, 0);
    tick();
    check("byp_out_opa", out_opa, 24'h000022);
    check("byp_out_opb", out_opb, 24'h000033);
    wb_addr = 3'd0; wb_data = 24'h000055;
    present(6'h04, 3'd0, 1, 3'd7, 1, 3'd0, 1);
    tick();
    wb_we = 0; in_valid = 0;
    check("x0_out_opa", out_opa, 0);
    check("x0_pend", dut.pend_q, 0);

    // backpressure: fields stable, then back-to-back transfer
    do_reset();
    out_ready = 0;
    rf_rd1 = 24'h000AAA;
    present(6'h03, 3'd1, 1, 3'd0, 0, 3'd2, 0);
    tick();
    rf_rd1 = 24'h000BBB;
    present(6'h04, 3'd4, 1, 3'd0, 0, 3'd2, 0);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("bp_in_ready%0d", i), in_ready, 0);
      tick();
      check($sformatf("bp_opa%0d", i), out_opa, 24'h000AAA);
    end
    check("bp_out_op", out_op, 6'h03);
    out_ready = 1;
    #1 check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("b2b_out_valid", out_valid, 1);
    check("b2b_out_op", out_op, 6'h04);
    check("b2b_out_opa", out_opa, 24'h000BBB);
    tick();
    check("drain_out_valid", out_valid, 0);

    // WAW stall, issue with same-cycle writeback: set wins
    do_reset();
    present(6'h05, 3'd0, 0, 3'd0, 0, 3'd5, 1);
    tick();
    present(6'h09, 3'd0, 0, 3'd0, 0, 3'd5, 1);
    #1 check("waw_in_ready", in_ready, 0);
    tick();
    check("waw_in_ready2", in_ready, 0);
    wb_we = 1; wb_addr = 3'd5;
    #1 check("waw_wb_ready", in_ready, 1);
    tick();
    wb_we = 0; in_valid = 0;
    check("waw_pend5", dut.pend_q[5], 1);
    check("waw_out_op", out_op, 6'h09);

    // flush releases held writer's scoreboard bit
    do_reset();
    out_ready = 0;
    present(6'h06, 3'd0, 0, 3'd0, 0, 3'd6, 1);
    tick();
    in_valid = 0;
    check("fl_pend6_set", dut.pend_q[6], 1);
    flush = 1;
    #1 check("fl_in_ready", in_ready, 0);
    tick();
    flush = 0;
    check("fl_out_valid", out_valid, 0);
    check("fl_pend6", dut.pend_q[6], 0);

    // stall counter saturation
    do_reset();
    present(6'h07, 3'd0, 0, 3'd0, 0, 3'd1, 1);
    tick();
    present(6'h08, 3'd1, 1, 3'd0, 0, 3'd2, 0);
    repeat (65534) @(posedge clk);
    #1 check("sat_fffe", stall_cnt, 16'hFFFE);
    repeat (5) @(posedge clk);
    #1 check("sat_ffff", stall_cnt, 16'hFFFF);
    in_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
